// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: round-robin arbiter of two write requesters onto the single register-file write port
//   clk, rst                      : rising-edge clock, synchronous active-low reset
//   req0_valid/addr/data, ready   : execute writeback requester (valid/ready handshake)
//   req1_valid/addr/data, ready   : load return requester (valid/ready handshake)
//   rf_wen, rf_waddr, rf_wdata    : registered write port into the register array
//   busy                          : init sweep in progress, no requests accepted
//   RF_INIT_SWEEP_EN (macro)      : when defined, every register is cleared after reset
module regfile_wport_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);
  logic              rr_q, rr_d, wen_q, wen_d, g0, g1, run;
  logic [ADDR_W-1:0] waddr_q, waddr_d, gaddr;
  logic [DATA_W-1:0] wdata_q, wdata_d, gdata;
`ifdef RF_INIT_SWEEP_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q, state_d;
  // extra top bit marks the sweep as finished, giving the one idle cycle before RUN
  logic [ADDR_W:0]   cnt_q, cnt_d;
  assign run = state_q == RUN;
`else
  assign run = 1'b1;
`endif
  assign busy       = !run;
  // rr_q names the requester that wins when both are valid
  assign g0         = rst && run && req0_valid && (!req1_valid || !rr_q);
  assign g1         = rst && run && req1_valid && (!req0_valid || rr_q);
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rf_wen     = wen_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  always_comb begin
    gaddr   = g1 ? req1_addr : req0_addr;
    gdata   = g1 ? req1_data : req0_data;
    // writes to a hardwired-zero r0 are accepted but never reach the array
    wen_d   = (g0 || g1) && !((R0_ZERO != 0) && gaddr == '0);
    waddr_d = wen_d ? gaddr : waddr_q;
    wdata_d = wen_d ? gdata : wdata_q;
    rr_d    = g0 ? 1'b1 : g1 ? 1'b0 : rr_q;
`ifdef RF_INIT_SWEEP_EN
    state_d = (!run && cnt_q[ADDR_W]) ? RUN : state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      wen_d   = !cnt_q[ADDR_W];
      waddr_d = cnt_q[ADDR_W] ? waddr_q : cnt_q[ADDR_W-1:0];
      wdata_d = cnt_q[ADDR_W] ? wdata_q : '0;
      cnt_d   = cnt_q + (ADDR_W+1)'(!cnt_q[ADDR_W]);
    end
`endif
  end
  always_ff @(posedge clk)
    if (!rst) begin
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef RF_INIT_SWEEP_EN
      state_q <= INIT;
      cnt_q   <= '0;
`endif
    end else begin
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef RF_INIT_SWEEP_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: vector table, sweep sequences and randomized model check of the write-port arbiter
module tb_regfile_wport_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  logic          clk = 1'b0, rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, rf_wen, busy;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  int            n_cmp = 0, n_bad = 0;
  int            m_rr;
  int            m_addr, m_data;
  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0, r1, wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } vec_t;
  vec_t tbl[15];
  regfile_wport_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic sweep_check(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk({tag, " sweep ready0"}, 32'(req0_ready), 0);
      chk({tag, " sweep ready1"}, 32'(req1_ready), 0);
      @(posedge clk); #1;
      chk({tag, " sweep wen"}, 32'(rf_wen), 1);
      chk({tag, " sweep addr"}, 32'(rf_waddr), 32'(k));
      chk({tag, " sweep data"}, 32'(rf_wdata), 0);
      chk({tag, " sweep busy"}, 32'(busy), 1);
    end
    @(posedge clk); #1;
    chk({tag, " sweep end busy"}, 32'(busy), 0);
    chk({tag, " sweep end wen"}, 32'(rf_wen), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 4'd3; req1_addr = 4'd4;
    #1;
    chk("rst ready0", 32'(req0_ready), 0);
    chk("rst ready1", 32'(req1_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst wen", 32'(rf_wen), 0);
    chk("rst waddr", 32'(rf_waddr), 0);
    chk("rst wdata", 32'(rf_wdata), 0);
`ifdef RF_INIT_SWEEP_EN
    chk("rst busy", 32'(busy), 1);
`else
    chk("rst busy", 32'(busy), 0);
`endif
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef RF_INIT_SWEEP_EN
    sweep_check("reset");
    m_addr = 15;
`else
    m_addr = 0;
`endif
    m_rr = 0; m_data = 0;
  endtask
  initial begin
    tbl[0]  = '{1, 4'd1,  16'h1111, 1, 4'd2,  16'h2222, 1, 0, 1, 4'd1,  16'h1111};
    tbl[1]  = '{1, 4'd1,  16'h1111, 1, 4'd2,  16'h2222, 0, 1, 1, 4'd2,  16'h2222};
    tbl[2]  = '{1, 4'd1,  16'h1111, 1, 4'd2,  16'h2222, 1, 0, 1, 4'd1,  16'h1111};
    tbl[3]  = '{1, 4'd1,  16'h1111, 1, 4'd2,  16'h2222, 0, 1, 1, 4'd2,  16'h2222};
    tbl[4]  = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0, 0, 4'd0,  16'h0000};
    tbl[5]  = '{1, 4'd5,  16'hBEEF, 0, 4'd0,  16'h0000, 1, 0, 1, 4'd5,  16'hBEEF};
    tbl[6]  = '{0, 4'd0,  16'h0000, 1, 4'd0,  16'hFFFF, 0, 1, 0, 4'd0,  16'h0000};
    tbl[7]  = '{1, 4'd3,  16'h3333, 1, 4'd4,  16'h4444, 1, 0, 1, 4'd3,  16'h3333};
    tbl[8]  = '{1, 4'd7,  16'hAAAA, 1, 4'd7,  16'h5555, 0, 1, 1, 4'd7,  16'h5555};
    tbl[9]  = '{1, 4'd7,  16'hAAAA, 0, 4'd0,  16'h0000, 1, 0, 1, 4'd7,  16'hAAAA};
    tbl[10] = '{1, 4'd0,  16'h1234, 0, 4'd0,  16'h0000, 1, 0, 0, 4'd0,  16'h0000};
    tbl[11] = '{0, 4'd0,  16'h0000, 1, 4'd15, 16'hFFFF, 0, 1, 1, 4'd15, 16'hFFFF};
    tbl[12] = '{1, 4'd9,  16'h0009, 1, 4'd10, 16'h000A, 1, 0, 1, 4'd9,  16'h0009};
    tbl[13] = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0, 0, 4'd0,  16'h0000};
    tbl[14] = '{1, 4'd11, 16'h0B0B, 1, 4'd12, 16'h0C0C, 0, 1, 1, 4'd12, 16'h0C0C};
`ifdef RF_INIT_SWEEP_EN
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h3333;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sweep_check("held");
    chk("held ready0 c17", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("held wen c18", 32'(rf_wen), 1);
    chk("held addr c18", 32'(rf_waddr), 3);
    chk("held data c18", 32'(rf_wdata), 32'h3333);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid addr before reset", 32'(rf_waddr), 9);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid reset wen", 32'(rf_wen), 0);
    chk("mid reset busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    sweep_check("restart");
`endif
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      #1;
      chk($sformatf("vec%0d ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
      chk($sformatf("vec%0d ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d wen", i), 32'(rf_wen), 32'(tbl[i].wen));
      if (tbl[i].wen) begin
        chk($sformatf("vec%0d waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
        chk($sformatf("vec%0d wdata", i), 32'(rf_wdata), 32'(tbl[i].wdata));
      end
    end
    do_reset();
    begin
      logic p0, p1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      int w, ea, ed;
      logic ewen;
      p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 79) == 0) begin
          do_reset();
          p0 = 0; p1 = 0;
        end
        if (!p0 && $urandom_range(0, 2) != 0) begin
          p0 = 1; a0 = AW'($urandom_range(0, 15)); d0 = DW'($urandom);
        end
        if (!p1 && $urandom_range(0, 2) != 0) begin
          p1 = 1; a1 = AW'($urandom_range(0, 15)); d1 = DW'($urandom);
        end
        @(negedge clk);
        req0_valid = p0; req0_addr = a0; req0_data = d0;
        req1_valid = p1; req1_addr = a1; req1_data = d1;
        w = (p0 && p1) ? m_rr : p0 ? 0 : p1 ? 1 : -1;
        ewen = 0;
        if (w >= 0) begin
          ea = (w == 1) ? int'(a1) : int'(a0);
          ed = (w == 1) ? int'(d1) : int'(d0);
          if (ea != 0) begin
            ewen = 1; m_addr = ea; m_data = ed;
          end
          m_rr = 1 - w;
        end
        #1;
        chk("rand ready0", 32'(req0_ready), 32'(w == 0));
        chk("rand ready1", 32'(req1_ready), 32'(w == 1));
        @(posedge clk); #1;
        chk("rand wen", 32'(rf_wen), 32'(ewen));
        chk("rand waddr", 32'(rf_waddr), 32'(m_addr));
        chk("rand wdata", 32'(rf_wdata), 32'(m_data));
        if (w == 0) p0 = 0;
        if (w == 1) p1 = 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
